adder_arbiter: RTL and testbench

Sequencing front end for the CPU's shared 32-bit adder. Up to NUM_REQ requesters (PC increment, branch target, load/store address generation) request additions. The block grants them round-robin, latches one operand pair, and drives the external adder instance for one cycle. It returns a tagged, registered sum under a valid/ready handshake, so only one adder is needed per core.

---
 rtl/adder_arbiter_pkg.sv | 16 +
 rtl/adder_arbiter_rr_picker.sv | 30 +++
 rtl/adder_arbiter.sv | 122 ++++++++++++
 tb/tb_adder_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_arbiter_pkg.sv
// Shared types and reset constants for the adder_arbiter front end.
package adder_arbiter_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

   localparam logic [DATA_W-1:0] RSP_RESULT_RST = '0;
   localparam int                RSP_ID_RST     = 0;

   // Pointer resets to the last requester so requester 0 is searched first.
   function automatic int last_rst(input int num_req);
      return num_req - 1;
   endfunction

endpackage

// File: rtl/adder_arbiter_rr_picker.sv
// Combinational round-robin picker: searches last+1, last+2, ... modulo NUM_REQ.
module rr_picker #(
   parameter int NUM_REQ = 3,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    last,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    win
);

   logic            found;
   logic [ID_W-1:0] idx;

   always_comb begin
      gnt   = '0;
      win   = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = ID_W'((int'(last) + k) % NUM_REQ);
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            win      = idx;
         end
      end
   end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin sequencer for the shared 32-bit adder with a tagged valid/ready result.
// Optional ADDER_ARBITER_SUB_EN adds per-requester req_sub to compute A-B.
module adder_arbiter
   import adder_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_b,
`ifdef ADDER_ARBITER_SUB_EN
   input  logic [NUM_REQ-1:0]        req_sub,
`endif
   output logic [NUM_REQ-1:0]        gnt,
   output logic [DATA_W-1:0]         add_a,
   output logic [DATA_W-1:0]         add_b,
   input  logic [DATA_W-1:0]         add_sum,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
   output logic [DATA_W-1:0]         rsp_result,
   output logic                      busy
);

   state_e              state_q, state_d;
   logic [ID_W-1:0]     last_q, last_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
   logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;

   logic                pick_en;
   logic [NUM_REQ-1:0]  pick_gnt;
   logic [ID_W-1:0]     win;
   logic                grant;
   logic [DATA_W-1:0]   b_sel;

   // Grants are only possible from IDLE or on a consumed response.
   assign pick_en = !reset && (state_q == IDLE || (state_q == RESP && rsp_ready));

   rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_picker (
      .req  (req & {NUM_REQ{pick_en}}),
      .last (last_q),
      .gnt  (pick_gnt),
      .win  (win)
   );

   assign grant = |pick_gnt;
   assign gnt   = pick_gnt;

   always_comb begin
      b_sel = req_b[int'(win)*DATA_W +: DATA_W];
`ifdef ADDER_ARBITER_SUB_EN
      if (req_sub[win]) b_sel = ~b_sel + DATA_W'(1);
`endif
   end

   always_comb begin
      state_d      = state_q;
      last_d       = last_q;
      id_d         = id_q;
      a_d          = a_q;
      b_d          = b_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      case (state_q)
         IDLE: if (grant) state_d = EXEC;
         EXEC: begin
            rsp_result_d = add_sum;
            rsp_id_d     = id_q;
            rsp_valid_d  = 1'b1;
            state_d      = RESP;
         end
         RESP: if (rsp_ready) begin
            rsp_valid_d = 1'b0;
            state_d     = grant ? EXEC : IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (grant) begin
         last_d = win;
         id_d   = win;
         a_d    = req_a[int'(win)*DATA_W +: DATA_W];
         b_d    = b_sel;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         last_q       <= ID_W'(last_rst(NUM_REQ));
         id_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= ID_W'(RSP_ID_RST);
         rsp_result_q <= RSP_RESULT_RST;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         id_q         <= id_d;
         a_q          <= a_d;
         b_q          <= b_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
      end
   end

   assign add_a      = (!reset && state_q == EXEC) ? a_q : '0;
   assign add_b      = (!reset && state_q == EXEC) ? b_q : '0;
   assign busy       = !reset && (state_q != IDLE);
   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter; responses are checked against a scoreboard queue.
module tb_adder_arbiter;

   localparam int N = 3;

   logic          clock = 1'b0;
   logic          reset;
   logic [N-1:0]  req;
   logic [N*32-1:0] req_a, req_b;
`ifdef ADDER_ARBITER_SUB_EN
   logic [N-1:0]  req_sub;
`endif
   logic [N-1:0]  gnt;
   logic [31:0]   add_a, add_b, add_sum;
   logic          rsp_valid, rsp_ready;
   logic [1:0]    rsp_id;
   logic [31:0]   rsp_result;
   logic          busy;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [1:0]  id;
      logic [31:0] res;
   } exp_t;
   exp_t sb[$];

   always #5 clock = ~clock;

   // The shared adder lives outside the arbiter.
   assign add_sum = add_a + add_b;

   adder_arbiter #(.NUM_REQ(N)) dut (
      .clock      (clock),
      .reset      (reset),
      .req        (req),
      .req_a      (req_a),
      .req_b      (req_b),
`ifdef ADDER_ARBITER_SUB_EN
      .req_sub    (req_sub),
`endif
      .gnt        (gnt),
      .add_a      (add_a),
      .add_b      (add_b),
      .add_sum    (add_sum),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .busy       (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
   endtask

   task automatic push(input logic [1:0] id, input logic [31:0] r);
      exp_t e;
      e.id  = id;
      e.res = r;
      sb.push_back(e);
   endtask

   // Every accepted response is popped and compared.
   always @(negedge clock) begin
      if (!reset && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL unexpected_rsp: observed id %0d result %h expected none", rsp_id, rsp_result);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_rsp_id", 32'(rsp_id), 32'(e.id));
            chk("sb_rsp_result", rsp_result, e.res);
         end
      end
   end

   logic [31:0] ta[N];
   logic [31:0] tb_b[N];

   initial begin
      reset = 1'b1; req = '1; req_a = '0; req_b = '0; rsp_ready = 1'b1;
`ifdef ADDER_ARBITER_SUB_EN
      req_sub = '0;
`endif
      // Reset state, with requests asserted to show they are ignored
      cyc(); #1;
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_add_a", add_a, 0);
      cyc(); reset = 1'b0; req = '0; #1;
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_id", 32'(rsp_id), 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_add_b", add_b, 0);

      // Single request
      cyc(); set_op(0, 32'h10FEDE01, 32'h00000001); req = 3'b001; push(0, 32'h10FEDE02); #1;
      chk("single_gnt", 32'(gnt), 32'b001);
      chk("single_busy_idle", 32'(busy), 0);
      cyc(); req = '0; #1;
      chk("single_exec_busy", 32'(busy), 1);
      chk("single_exec_add_a", add_a, 32'h10FEDE01);
      chk("single_exec_add_b", add_b, 32'h00000001);
      chk("single_exec_valid", 32'(rsp_valid), 0);
      cyc(); #1;
      chk("single_valid", 32'(rsp_valid), 1);
      chk("single_rsp_id", 32'(rsp_id), 0);
      chk("single_rsp_result", rsp_result, 32'h10FEDE02);
      cyc(); #1;
      chk("single_idle_valid", 32'(rsp_valid), 0);
      chk("single_idle_busy", 32'(busy), 0);

      // All three requesting from a fresh pointer
      reset = 1'b1; cyc(); reset = 1'b0;
      for (int i = 0; i < N; i++) begin
         ta[i]   = 32'h10000000 * (i + 1) + 32'h0000ABCD;
         tb_b[i] = 32'(i + 7);
         set_op(i, ta[i], tb_b[i]);
      end
      req = 3'b111;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("rr_gnt", 32'(gnt), 32'(1 << (k % N)));
         push(2'(k % N), ta[k % N] + tb_b[k % N]);
         cyc();
         if (k == 3) req = '0;
         #1;
         chk("rr_exec_gnt", 32'(gnt), 0);
         cyc();
      end
      #1;
      chk("rr_last_gnt", 32'(gnt), 0);
      cyc();

      // Backpressure with req[1] pending
      set_op(1, 32'h000049DF, 32'h0000029A); req = 3'b010; #1;
      chk("bp_first_gnt", 32'(gnt), 32'b010);
      push(1, 32'h00004C79);
      cyc(); rsp_ready = 1'b0;
      cyc();
      for (int n = 0; n < 5; n++) begin
         #1;
         chk("bp_valid", 32'(rsp_valid), 1);
         chk("bp_result", rsp_result, 32'h00004C79);
         chk("bp_id", 32'(rsp_id), 1);
         chk("bp_no_gnt", 32'(gnt), 0);
         cyc();
      end
      rsp_ready = 1'b1; #1;
      chk("bp_release_gnt", 32'(gnt), 32'b010);
      push(1, 32'h00004C79);
      cyc(); req = '0;
      cyc();
      cyc(); #1;
      chk("bp_idle_busy", 32'(busy), 0);

      // Negative operand
      cyc(); set_op(0, 32'h00000005, 32'hFFFFFFFE); req = 3'b001; #1;
      chk("neg_gnt", 32'(gnt), 32'b001);
      push(0, 32'h00000003);
      cyc(); req = '0;
      cyc(); #1;
      chk("neg_result", rsp_result, 32'h00000003);
      cyc();

      // Reset while EXEC; the aborted op must never respond
      set_op(0, 32'h00001111, 32'h00002222); req = 3'b001; #1;
      chk("abort_gnt", 32'(gnt), 32'b001);
      cyc(); req = '0; #1;
      chk("abort_exec_busy", 32'(busy), 1);
      reset = 1'b1; #1;
      chk("abort_rst_gnt", 32'(gnt), 0);
      chk("abort_rst_busy", 32'(busy), 0);
      chk("abort_rst_add_a", add_a, 0);
      cyc(); reset = 1'b0; #1;
      chk("abort_valid0", 32'(rsp_valid), 0);
      chk("abort_busy0", 32'(busy), 0);
      cyc(); #1;
      chk("abort_valid1", 32'(rsp_valid), 0);
      // Pointer restarted: req[0] wins over req[2]
      set_op(0, 32'h00000100, 32'h00000001);
      set_op(2, 32'h00000200, 32'h00000002);
      req = 3'b101; #1;
      chk("post_rst_contest_gnt", 32'(gnt), 32'b001);
      push(0, 32'h00000101);
      cyc(); req = 3'b100;
      cyc(); #1;
      chk("post_rst_req2_gnt", 32'(gnt), 32'b100);
      push(2, 32'h00000202);
      cyc(); req = '0;
      cyc();
      cyc();

`ifdef ADDER_ARBITER_SUB_EN
      set_op(1, 32'h00000010, 32'h00000003); req_sub = 3'b010; req = 3'b010; #1;
      chk("sub_gnt", 32'(gnt), 32'b010);
      push(1, 32'h0000000D);
      cyc(); req = '0; req_sub = '0;
      cyc(); #1;
      chk("sub_result", rsp_result, 32'h0000000D);
      cyc();
      set_op(2, 32'h00000000, 32'h80000000); req_sub = 3'b100; req = 3'b100; #1;
      chk("sub_min_gnt", 32'(gnt), 32'b100);
      push(2, 32'h80000000);
      cyc(); req = '0; req_sub = '0;
      cyc();
      cyc();
`endif

      repeat (2) cyc();
      chk("sb_drained", 32'(sb.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
